// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC sequencer, internal instruction memory and a prefetch queue.
// Latency: a read issued in a cycle lands in the queue at that cycle's closing edge; valid one cycle after issue.
// Backpressure: instr_ready low holds the head; reads stop issuing once the queue is full.
module instr_fetch_unit #(
  parameter int          DATA_W     = 32,
  parameter int          ADDR_W     = 12,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instruction,
  output logic [31:0]       instr_pc,
  output logic [31:0]       fetch_pc
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  typedef struct packed {
    logic [31:0]       pc;
    logic [DATA_W-1:0] dat;
  } entry_t;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  entry_t            queue [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              issue;
  logic              pop;
  logic [ADDR_W-1:0] rd_idx;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];
  assign rd_idx = fetch_pc[ADDR_W+1:2];

  // The memory read itself is synchronous: the queue entry acts as the RAM output register.
  assign issue = enable && !redirect && !rst && (count < CNT_MAX);
  assign pop   = instr_valid && instr_ready && !redirect && !rst;

  assign instr_valid = (count != '0);
  assign instruction = instr_valid ? queue[rd_ptr].dat : '0;
  assign instr_pc    = instr_valid ? queue[rd_ptr].pc  : '0;

  // Write is non-blocking, so a same-edge read of the same word sees the old contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      queue[wr_ptr] <= '{pc: fetch_pc, dat: mem[rd_idx]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case ({issue, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised and directed bench for instr_fetch_unit against a queue-based reference model.
module tb_instr_fetch_unit;

  localparam int DEPTH = 4;
  localparam int AW    = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          redirect = 1'b0;
  logic [31:0]   redirect_pc = '0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [31:0]   wr_data = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [31:0]   instruction;
  logic [31:0]   instr_pc;
  logic [31:0]   fetch_pc;

  int tests_run = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] dat;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc;
  logic [31:0] mmem [2**AW];

  instr_fetch_unit #(.DATA_W(32), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .redirect(redirect), .redirect_pc(redirect_pc),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instruction(instruction), .instr_pc(instr_pc), .fetch_pc(fetch_pc)
  );

  always #5 clk = ~clk;

  // One clock edge; the model applies the rules of that edge from the inputs then present.
  task automatic tick();
    logic        can_push;
    logic [31:0] rd;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mpc = 32'h0;
    end else if (redirect) begin
      mq.delete();
      mpc = {redirect_pc[31:2], 2'b00};
    end else begin
      can_push = enable && (mq.size() < DEPTH);
      rd = mmem[mpc[AW+1:2]];
      if (instr_ready && mq.size() > 0) void'(mq.pop_front());
      if (can_push) begin
        mq.push_back('{pc: mpc, dat: rd});
        mpc = mpc + 32'd4;
      end
    end
    if (wr_en) mmem[wr_addr] = wr_data;
    #1;
  endtask

  function automatic logic [96:0] model_outs();
    logic v;
    v = (mq.size() > 0);
    return {v, v ? mq[0].dat : 32'h0, v ? mq[0].pc : 32'h0, mpc};
  endfunction

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < (2**AW); i++) begin
      wr_en = 1'b1; wr_addr = AW'(i);
      wr_data = (i < 8) ? 32'hA0 + 32'(i) : $urandom;
      tick();
    end
    wr_en = 1'b0;
    tests_run++;
    if ({instr_valid, instruction, instr_pc, fetch_pc} !== {1'b0, 32'h0, 32'h0, 32'h0}) begin
      fails++;
      $display("FAIL reset_state: got v=%b i=%h pc=%h fpc=%h, want 0/0/0/0",
               instr_valid, instruction, instr_pc, fetch_pc);
    end
  endtask

  task automatic test_seq_fetch();
    rst = 1'b0; enable = 1'b1; instr_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      tests_run++;
      if ({instr_valid, instruction, instr_pc} !== {1'b1, 32'hA0 + 32'(k), 32'(4 * k)}) begin
        fails++;
        $display("FAIL seq_fetch[%0d]: got v=%b i=%h pc=%h, want 1/%h/%h",
                 k, instr_valid, instruction, instr_pc, 32'hA0 + 32'(k), 4 * k);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got[$];
    rst = 1'b1; tick(); rst = 1'b0;
    instr_ready = 1'b0; enable = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    tests_run++;
    if ({instr_valid, instruction, fetch_pc} !== {1'b1, 32'hA0, 32'h10}) begin
      fails++;
      $display("FAIL backpressure_fill: got v=%b i=%h fpc=%h, want 1/a0/10",
               instr_valid, instruction, fetch_pc);
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (instr_valid) got.push_back(instruction);
      tick();
      tests_run++;
      if ({instr_valid, instruction, instr_pc, fetch_pc} !== model_outs()) begin
        fails++;
        $display("FAIL backpressure_drain[%0d]: got %h want %h", i,
                 {instr_valid, instruction, instr_pc, fetch_pc}, model_outs());
      end
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (got.size() <= i || got[i] !== 32'hA0 + 32'(i)) begin
        fails++;
        $display("FAIL backpressure_order[%0d]: got %h want %h", i,
                 (got.size() > i) ? got[i] : 32'hx, 32'hA0 + 32'(i));
      end
    end
  endtask

  task automatic test_redirect();
    rst = 1'b1; tick(); rst = 1'b0;
    instr_ready = 1'b0; enable = 1'b1;
    tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0016;
    tick();
    redirect = 1'b0;
    tests_run++;
    if ({instr_valid, fetch_pc} !== {1'b0, 32'h14}) begin
      fails++;
      $display("FAIL redirect_flush: got v=%b fpc=%h, want 0/14", instr_valid, fetch_pc);
    end
    tick();
    tests_run++;
    if ({instr_valid, instruction, instr_pc} !== {1'b1, 32'hA5, 32'h14}) begin
      fails++;
      $display("FAIL redirect_head: got v=%b i=%h pc=%h, want 1/a5/14", instr_valid, instruction, instr_pc);
    end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'h0000_3FFC; instr_ready = 1'b0;
    tick();
    redirect = 1'b0;
    tick(); tick();
    tests_run++;
    if ({instr_valid, instruction, instr_pc} !== {1'b1, mmem[4095], 32'h3FFC}) begin
      fails++;
      $display("FAIL wrap_last: got v=%b i=%h pc=%h, want 1/%h/3ffc", instr_valid, instruction, instr_pc, mmem[4095]);
    end
    instr_ready = 1'b1;
    tick();
    tests_run++;
    if ({instr_valid, instruction, instr_pc} !== {1'b1, 32'hA0, 32'h4000}) begin
      fails++;
      $display("FAIL wrap_alias: got v=%b i=%h pc=%h, want 1/a0/4000", instr_valid, instruction, instr_pc);
    end
  endtask

  task automatic test_reset_mid();
    redirect = 1'b1; redirect_pc = 32'h0; instr_ready = 1'b0; tick();
    redirect = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if ({instr_valid, instruction, instr_pc, fetch_pc} !== {1'b0, 32'h0, 32'h0, 32'h0}) begin
      fails++;
      $display("FAIL reset_mid: got v=%b i=%h pc=%h fpc=%h, want 0/0/0/0", instr_valid, instruction, instr_pc, fetch_pc);
    end
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if (instruction !== 32'hA0 + 32'(k)) begin
        fails++;
        $display("FAIL reset_mem_kept[%0d]: got %h want %h", k, instruction, 32'hA0 + 32'(k));
      end
    end
  endtask

  task automatic test_rw_same();
    instr_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'hC; tick();
    redirect = 1'b0;
    wr_en = 1'b1; wr_addr = AW'(3); wr_data = 32'h55;
    tick();
    wr_en = 1'b0;
    tests_run++;
    if ({instr_valid, instruction, instr_pc} !== {1'b1, 32'hA3, 32'hC}) begin
      fails++;
      $display("FAIL rw_old_data: got v=%b i=%h pc=%h, want 1/a3/c", instr_valid, instruction, instr_pc);
    end
    redirect = 1'b1; tick();
    redirect = 1'b0; tick();
    tests_run++;
    if (instruction !== 32'h55) begin
      fails++;
      $display("FAIL rw_new_data: got %h want 55", instruction);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      enable      = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      rst         = ($urandom_range(0, 63) == 0);
      wr_en       = ($urandom_range(0, 4) == 0);
      wr_addr     = AW'($urandom_range(0, 15));
      wr_data     = $urandom;
      tick();
      tests_run++;
      if ({instr_valid, instruction, instr_pc, fetch_pc} !== model_outs()) begin
        fails++;
        $display("FAIL random[%0d]: got %h want %h", i, {instr_valid, instruction, instr_pc, fetch_pc}, model_outs());
      end
    end
    rst = 1'b0; redirect = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_rw_same();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
